ctrl_pipeline: RTL and testbench

- Consumes the per-instruction control bundle produced by the opcode decoder in ID.
- Carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards (stall and bubble insertion) and applies branch flushes.
- Generates EX-stage forwarding selects.
- Sits between the decoder and the datapath stage registers of the 5-stage MIPS core.

---
 rtl/ctrl_pipeline_pkg.sv | 66 ++++++
 rtl/ctrl_pipeline_fwd_unit.sv | 20 ++
 rtl/ctrl_pipeline.sv | 161 ++++++++++++++++
 tb/tb_ctrl_pipeline.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipeline_pkg.sv
// Shared types and constants for the pipeline control path: decoder bundle,
// per-stage control subsets and forwarding select encodings.
package ctrl_pipeline_pkg;

    localparam int RA_W     = 5;
    localparam int ALU_OP_W = 6;

    typedef struct packed {
        logic                reg_dest;
        logic                alu_src;
        logic                mem_to_reg;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    // reg_dest is consumed in ID when the destination is chosen, so later
    // stages only carry what they still need.
    typedef struct packed {
        logic                alu_src;
        logic                mem_to_reg;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
        logic [ALU_OP_W-1:0] alu_op;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } mem_ctrl_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } wb_ctrl_t;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Newest producer wins; $0 is hard-wired and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] src,
        input logic            mem_rw,
        input logic [RA_W-1:0] mem_dst,
        input logic            wb_rw,
        input logic [RA_W-1:0] wb_dst
    );
        if (mem_rw && (mem_dst != '0) && (mem_dst == src)) begin
            return FWD_EXMEM;
        end else if (wb_rw && (wb_dst != '0) && (wb_dst == src)) begin
            return FWD_MEMWB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/ctrl_pipeline_fwd_unit.sv
// EX-stage forwarding selects for both ALU source operands.
module ctrl_pipeline_fwd_unit
    import ctrl_pipeline_pkg::*;
(
    input  logic [RA_W-1:0] ex_rs,
    input  logic [RA_W-1:0] ex_rt,
    input  logic            mem_reg_write,
    input  logic [RA_W-1:0] mem_dst,
    input  logic            wb_reg_write,
    input  logic [RA_W-1:0] wb_dst,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
);

    always_comb begin
        fwd_a = fwd_sel(ex_rs, mem_reg_write, mem_dst, wb_reg_write, wb_dst);
        fwd_b = fwd_sel(ex_rt, mem_reg_write, mem_dst, wb_reg_write, wb_dst);
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Control-side pipeline registers (ID/EX, EX/MEM, MEM/WB) with load-use
// stall, branch flush and forwarding select generation.
module ctrl_pipeline
    import ctrl_pipeline_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                id_reg_dest,
    input  logic                id_alu_src,
    input  logic                id_mem_to_reg,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic                id_branch,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic [RA_W-1:0]     id_rs,
    input  logic [RA_W-1:0]     id_rt,
    input  logic [RA_W-1:0]     id_rd,
    input  logic                mem_branch_taken,
    output logic                stall,
    output logic                ex_alu_src,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [RA_W-1:0]     ex_rs,
    output logic [RA_W-1:0]     ex_rt,
    output logic [RA_W-1:0]     ex_dst,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic                mem_mem_read,
    output logic                mem_mem_write,
    output logic                mem_branch,
    output logic                mem_reg_write,
    output logic [RA_W-1:0]     mem_dst,
    output logic                wb_reg_write,
    output logic                wb_mem_to_reg,
    output logic [RA_W-1:0]     wb_dst
);

    ctrl_t           id_ctrl;
    ctrl_t           id_sel;
    logic            load_use;
    logic            stall_int;
    logic            ex_bubble;

    ex_ctrl_t        ex_ctrl_q, ex_ctrl_d;
    logic [RA_W-1:0] ex_rs_q, ex_rs_d;
    logic [RA_W-1:0] ex_rt_q, ex_rt_d;
    logic [RA_W-1:0] ex_dst_q, ex_dst_d;
    mem_ctrl_t       mem_ctrl_q, mem_ctrl_d;
    logic [RA_W-1:0] mem_dst_q, mem_dst_d;
    wb_ctrl_t        wb_ctrl_q, wb_ctrl_d;
    logic [RA_W-1:0] wb_dst_q, wb_dst_d;

    always_comb begin
        id_ctrl.reg_dest   = id_reg_dest;
        id_ctrl.alu_src    = id_alu_src;
        id_ctrl.mem_to_reg = id_mem_to_reg;
        id_ctrl.reg_write  = id_reg_write;
        id_ctrl.mem_read   = id_mem_read;
        id_ctrl.mem_write  = id_mem_write;
        id_ctrl.branch     = id_branch;
        id_ctrl.alu_op     = id_alu_op;
    end

    // A taken branch already squashes ID, so the stall request is dropped.
    always_comb begin
        load_use  = ex_ctrl_q.mem_read && (ex_dst_q != '0) &&
                    ((ex_dst_q == id_rs) || (ex_dst_q == id_rt));
        stall_int = ena && !mem_branch_taken && load_use;
        ex_bubble = mem_branch_taken || stall_int;
        id_sel    = ex_bubble ? BUBBLE : id_ctrl;
    end

    always_comb begin
        ex_ctrl_d  = ex_ctrl_q;
        ex_rs_d    = ex_rs_q;
        ex_rt_d    = ex_rt_q;
        ex_dst_d   = ex_dst_q;
        mem_ctrl_d = mem_ctrl_q;
        mem_dst_d  = mem_dst_q;
        wb_ctrl_d  = wb_ctrl_q;
        wb_dst_d   = wb_dst_q;
        if (ena) begin
            ex_ctrl_d.alu_src    = id_sel.alu_src;
            ex_ctrl_d.mem_to_reg = id_sel.mem_to_reg;
            ex_ctrl_d.reg_write  = id_sel.reg_write;
            ex_ctrl_d.mem_read   = id_sel.mem_read;
            ex_ctrl_d.mem_write  = id_sel.mem_write;
            ex_ctrl_d.branch     = id_sel.branch;
            ex_ctrl_d.alu_op     = id_sel.alu_op;
            ex_rs_d              = ex_bubble ? '0 : id_rs;
            ex_rt_d              = ex_bubble ? '0 : id_rt;
            ex_dst_d             = ex_bubble ? '0 : (id_sel.reg_dest ? id_rd : id_rt);

            if (mem_branch_taken) begin
                mem_ctrl_d = '0;
                mem_dst_d  = '0;
            end else begin
                mem_ctrl_d.mem_to_reg = ex_ctrl_q.mem_to_reg;
                mem_ctrl_d.reg_write  = ex_ctrl_q.reg_write;
                mem_ctrl_d.mem_read   = ex_ctrl_q.mem_read;
                mem_ctrl_d.mem_write  = ex_ctrl_q.mem_write;
                mem_ctrl_d.branch     = ex_ctrl_q.branch;
                mem_dst_d             = ex_dst_q;
            end

            wb_ctrl_d.mem_to_reg = mem_ctrl_q.mem_to_reg;
            wb_ctrl_d.reg_write  = mem_ctrl_q.reg_write;
            wb_dst_d             = mem_dst_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_ctrl_q  <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_dst_q   <= '0;
            mem_ctrl_q <= '0;
            mem_dst_q  <= '0;
            wb_ctrl_q  <= '0;
            wb_dst_q   <= '0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_dst_q   <= ex_dst_d;
            mem_ctrl_q <= mem_ctrl_d;
            mem_dst_q  <= mem_dst_d;
            wb_ctrl_q  <= wb_ctrl_d;
            wb_dst_q   <= wb_dst_d;
        end
    end

    ctrl_pipeline_fwd_unit u_fwd (
        .ex_rs         (ex_rs_q),
        .ex_rt         (ex_rt_q),
        .mem_reg_write (mem_ctrl_q.reg_write),
        .mem_dst       (mem_dst_q),
        .wb_reg_write  (wb_ctrl_q.reg_write),
        .wb_dst        (wb_dst_q),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    assign stall         = stall_int;
    assign ex_alu_src    = ex_ctrl_q.alu_src;
    assign ex_alu_op     = ex_ctrl_q.alu_op;
    assign ex_rs         = ex_rs_q;
    assign ex_rt         = ex_rt_q;
    assign ex_dst        = ex_dst_q;
    assign mem_mem_read  = mem_ctrl_q.mem_read;
    assign mem_mem_write = mem_ctrl_q.mem_write;
    assign mem_branch    = mem_ctrl_q.branch;
    assign mem_reg_write = mem_ctrl_q.reg_write;
    assign mem_dst       = mem_dst_q;
    assign wb_reg_write  = wb_ctrl_q.reg_write;
    assign wb_mem_to_reg = wb_ctrl_q.mem_to_reg;
    assign wb_dst        = wb_dst_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: latency, load-use stall, forwarding,
// $0 handling, flush, enable freeze and asynchronous reset.
module tb_ctrl_pipeline;
    import ctrl_pipeline_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                ena;
    logic                id_reg_dest, id_alu_src, id_mem_to_reg, id_reg_write;
    logic                id_mem_read, id_mem_write, id_branch;
    logic [ALU_OP_W-1:0] id_alu_op;
    logic [RA_W-1:0]     id_rs, id_rt, id_rd;
    logic                mem_branch_taken;
    logic                stall, ex_alu_src;
    logic [ALU_OP_W-1:0] ex_alu_op;
    logic [RA_W-1:0]     ex_rs, ex_rt, ex_dst;
    logic [1:0]          fwd_a, fwd_b;
    logic                mem_mem_read, mem_mem_write, mem_branch, mem_reg_write;
    logic [RA_W-1:0]     mem_dst;
    logic                wb_reg_write, wb_mem_to_reg;
    logic [RA_W-1:0]     wb_dst;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    ctrl_pipeline dut (
        .clk(clk), .rst(rst), .ena(ena),
        .id_reg_dest(id_reg_dest), .id_alu_src(id_alu_src),
        .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_branch(id_branch), .id_alu_op(id_alu_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .mem_branch_taken(mem_branch_taken),
        .stall(stall), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_branch(mem_branch), .mem_reg_write(mem_reg_write), .mem_dst(mem_dst),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic rdst, input logic asrc, input logic m2r,
                          input logic rw, input logic mr, input logic mw,
                          input logic br, input logic [5:0] op,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd);
        id_reg_dest = rdst; id_alu_src = asrc; id_mem_to_reg = m2r;
        id_reg_write = rw;  id_mem_read = mr;  id_mem_write = mw;
        id_branch = br;     id_alu_op = op;
        id_rs = rs; id_rt = rt; id_rd = rd;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 6'h00, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {stall, ex_alu_src, ex_alu_op, ex_rs, ex_rt, ex_dst, fwd_a, fwd_b,
                  mem_mem_read, mem_mem_write, mem_branch, mem_reg_write, mem_dst,
                  wb_reg_write, wb_mem_to_reg, wb_dst}, 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        ena = 1'b1;
        mem_branch_taken = 1'b0;
        set_id(1, 0, 0, 1, 0, 0, 0, 6'h20, 5'd1, 5'd2, 5'd3);
        tick();
        tick();
        chk_zero("reset_hold");
        rst = 1'b1;

        // latency: add $3, then sw
        tick();
        chk("add_ex", {ex_dst, ex_alu_op, ex_alu_src, ex_rs, ex_rt},
            {5'd3, 6'h20, 1'b0, 5'd1, 5'd2});
        set_id(0, 1, 0, 0, 0, 1, 0, 6'h2b, 5'd1, 5'd2, 5'd0);
        tick();
        chk("add_mem", {mem_reg_write, mem_dst, mem_mem_write, ex_alu_src},
            {1'b1, 5'd3, 1'b0, 1'b1});
        nop();
        tick();
        chk("add_wb", {wb_reg_write, wb_dst, wb_mem_to_reg, mem_mem_write, mem_reg_write},
            {1'b1, 5'd3, 1'b0, 1'b1, 1'b0});
        drain();

        // load-use on $5
        set_id(0, 1, 1, 1, 1, 0, 0, 6'h21, 5'd1, 5'd5, 5'd0);
        tick();
        set_id(1, 0, 0, 1, 0, 0, 0, 6'h20, 5'd5, 5'd6, 5'd7);
        #1;
        chk("lu_stall", stall, 1'b1);
        tick();
        chk("lu_bubble", {stall, ex_alu_op, ex_dst, ex_rs, mem_mem_read, mem_dst},
            {1'b0, 6'h00, 5'd0, 5'd0, 1'b1, 5'd5});
        tick();
        chk("lu_fwd", {ex_rs, ex_dst, fwd_a, fwd_b, wb_reg_write, wb_mem_to_reg, wb_dst},
            {5'd5, 5'd7, 2'b01, 2'b00, 1'b1, 1'b1, 5'd5});
        drain();

        // back-to-back producer/consumer on $4
        set_id(1, 0, 0, 1, 0, 0, 0, 6'h20, 5'd1, 5'd2, 5'd4);
        tick();
        set_id(1, 0, 0, 1, 0, 0, 0, 6'h22, 5'd4, 5'd4, 5'd8);
        tick();
        chk("fwd_exmem", {fwd_a, fwd_b}, {2'b10, 2'b10});
        drain();

        // one unrelated instruction between
        set_id(1, 0, 0, 1, 0, 0, 0, 6'h20, 5'd1, 5'd2, 5'd4);
        tick();
        set_id(1, 0, 0, 1, 0, 0, 0, 6'h24, 5'd1, 5'd2, 5'd9);
        tick();
        set_id(1, 0, 0, 1, 0, 0, 0, 6'h22, 5'd4, 5'd4, 5'd8);
        tick();
        chk("fwd_memwb", {fwd_a, fwd_b}, {2'b01, 2'b01});
        drain();

        // two producers of $4: newest wins
        set_id(1, 0, 0, 1, 0, 0, 0, 6'h20, 5'd1, 5'd2, 5'd4);
        tick();
        set_id(1, 0, 0, 1, 0, 0, 0, 6'h25, 5'd1, 5'd2, 5'd4);
        tick();
        set_id(1, 0, 0, 1, 0, 0, 0, 6'h22, 5'd4, 5'd4, 5'd8);
        tick();
        chk("fwd_prio", {fwd_a, fwd_b}, {2'b10, 2'b10});
        drain();

        // $0 never forwards or stalls
        set_id(1, 0, 0, 1, 0, 0, 0, 6'h20, 5'd1, 5'd2, 5'd0);
        tick();
        set_id(1, 0, 0, 1, 0, 0, 0, 6'h20, 5'd1, 5'd2, 5'd0);
        tick();
        set_id(1, 0, 0, 1, 0, 0, 0, 6'h20, 5'd0, 5'd0, 5'd10);
        tick();
        chk("r0_fwd", {fwd_a, fwd_b, mem_reg_write, wb_reg_write}, {2'b00, 2'b00, 1'b1, 1'b1});
        drain();
        set_id(0, 1, 1, 1, 1, 0, 0, 6'h21, 5'd1, 5'd0, 5'd0);
        tick();
        set_id(1, 0, 0, 1, 0, 0, 0, 6'h20, 5'd0, 5'd0, 5'd10);
        #1;
        chk("r0_nostall", stall, 1'b0);
        tick();
        chk("r0_enter", {ex_dst, fwd_a, fwd_b, mem_mem_read}, {5'd10, 2'b00, 2'b00, 1'b1});
        drain();

        // flush coinciding with a load-use condition
        set_id(0, 0, 0, 0, 0, 0, 1, 6'h22, 5'd1, 5'd2, 5'd0);
        tick();
        set_id(0, 1, 1, 1, 1, 0, 0, 6'h21, 5'd1, 5'd5, 5'd0);
        tick();
        set_id(1, 0, 0, 1, 0, 0, 0, 6'h20, 5'd5, 5'd6, 5'd7);
        mem_branch_taken = 1'b1;
        #1;
        chk("fl_stall", {stall, mem_branch}, {1'b0, 1'b1});
        tick();
        mem_branch_taken = 1'b0;
        chk("fl_bubble", {ex_alu_op, ex_dst, mem_mem_read, mem_mem_write, mem_reg_write, mem_branch},
            {6'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("fl_retire", {wb_dst, wb_reg_write}, {5'd2, 1'b0});
        drain();

        // enable freeze mid-stream
        set_id(1, 0, 0, 1, 0, 0, 0, 6'h20, 5'd1, 5'd2, 5'd3);
        tick();
        set_id(1, 0, 0, 1, 0, 0, 0, 6'h20, 5'd1, 5'd2, 5'd9);
        tick();
        set_id(0, 1, 1, 1, 1, 0, 0, 6'h21, 5'd3, 5'd5, 5'd0);
        tick();
        set_id(1, 0, 0, 1, 0, 0, 0, 6'h20, 5'd5, 5'd3, 5'd7);
        #1;
        chk("en_pre_stall", stall, 1'b1);
        ena = 1'b0;
        #1;
        chk("en_stall_off", stall, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en_hold", {stall, ex_dst, ex_alu_op, mem_dst, mem_reg_write, wb_dst, fwd_a, fwd_b},
                {1'b0, 5'd5, 6'h21, 5'd9, 1'b1, 5'd3, 2'b01, 2'b00});
        end
        ena = 1'b1;
        #1;
        chk("en_resume_stall", stall, 1'b1);
        tick();
        chk("en_resume", {ex_alu_op, ex_dst, mem_mem_read, mem_dst, wb_dst},
            {6'h00, 5'd0, 1'b1, 5'd5, 5'd9});

        // asynchronous reset mid-stream
        #2;
        rst = 1'b0;
        #1;
        chk_zero("async_rst");
        tick();
        chk_zero("rst_held");
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
